// File: rtl/cache_pkg.sv
// Shared types and helpers for the parametrised write-back cache controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    localparam logic RWB_READ  = 1'b1;
    localparam logic RWB_WRITE = 1'b0;

    function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned index_w);
        return addr_w - index_w;
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Direct-mapped line storage: valid/dirty flags (async cleared) plus tag/data arrays.
module cache_line_array #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned TAG_W   = 3,
    parameter int unsigned DATA_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rd_idx,
    output logic               rd_valid_c,
    output logic               rd_dirty_c,
    output logic [TAG_W-1:0]   rd_tag_c,
    output logic [DATA_W-1:0]  rd_data_c,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_idx,
    input  logic               wr_dirty,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [DATA_W-1:0]  wr_data
);
    localparam int unsigned LINES = 2 ** INDEX_W;

    logic [LINES-1:0]  valid_q;
    logic [LINES-1:0]  dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    // Every write installs a line, so it always becomes valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
            dirty_q[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data contents are meaningless until valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid_c = valid_q[rd_idx];
    assign rd_dirty_c = dirty_q[rd_idx];
    assign rd_tag_c   = tag_q[rd_idx];
    assign rd_data_c  = data_q[rd_idx];

endmodule

// File: rtl/param_wb_cache.sv
// Direct-mapped write-back, write-allocate cache controller with CPU valid/ready and memory req/ack.
module param_wb_cache
    import cache_pkg::*;
#(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_rwb,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic              mem_req_valid,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int unsigned TAG_W = tag_width(ADDR_W, INDEX_W);

    state_t             state, state_n;
    logic               req_rwb, req_rwb_n;
    logic [ADDR_W-1:0]  req_addr, req_addr_n;
    logic [DATA_W-1:0]  req_wdata, req_wdata_n;
    logic               ready_n, resp_valid_n, hit_n;
    logic [DATA_W-1:0]  rdata_n;
    logic               mreq_valid_n, mreq_we_n;
    logic [ADDR_W-1:0]  maddr_n;
    logic [DATA_W-1:0]  mwdata_n;
    logic [CNT_W-1:0]   hit_cnt_n, miss_cnt_n;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic               line_valid_c, line_dirty_c, lookup_hit_c, mem_done_c;
    logic [TAG_W-1:0]   line_tag_c;
    logic [DATA_W-1:0]  line_data_c;
    logic               wr_en, wr_dirty;
    logic [DATA_W-1:0]  wr_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign idx          = req_addr[INDEX_W-1:0];
    assign req_tag      = req_addr[ADDR_W-1:INDEX_W];
    assign lookup_hit_c = line_valid_c && (line_tag_c == req_tag);
    assign mem_done_c   = mem_req_valid && mem_ack;

    cache_line_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W),
        .DATA_W  (DATA_W)
    ) u_lines (
        .clk        (clk),
        .reset      (reset),
        .rd_idx     (idx),
        .rd_valid_c (line_valid_c),
        .rd_dirty_c (line_dirty_c),
        .rd_tag_c   (line_tag_c),
        .rd_data_c  (line_data_c),
        .wr_en      (wr_en),
        .wr_idx     (idx),
        .wr_dirty   (wr_dirty),
        .wr_tag     (req_tag),
        .wr_data    (wr_data)
    );

    // State and all outputs are registered together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            req_rwb        <= RWB_READ;
            req_addr       <= '0;
            req_wdata      <= '0;
            cpu_req_ready  <= 1'b1;
            cpu_resp_valid <= 1'b0;
            cpu_rdata      <= '0;
            cpu_hit        <= 1'b0;
            mem_req_valid  <= 1'b0;
            mem_req_we     <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            hit_count      <= '0;
            miss_count     <= '0;
        end else begin
            state          <= state_n;
            req_rwb        <= req_rwb_n;
            req_addr       <= req_addr_n;
            req_wdata      <= req_wdata_n;
            cpu_req_ready  <= ready_n;
            cpu_resp_valid <= resp_valid_n;
            cpu_rdata      <= rdata_n;
            cpu_hit        <= hit_n;
            mem_req_valid  <= mreq_valid_n;
            mem_req_we     <= mreq_we_n;
            mem_addr       <= maddr_n;
            mem_wdata      <= mwdata_n;
            hit_count      <= hit_cnt_n;
            miss_count     <= miss_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        req_rwb_n    = req_rwb;
        req_addr_n   = req_addr;
        req_wdata_n  = req_wdata;
        ready_n      = cpu_req_ready;
        resp_valid_n = 1'b0;
        rdata_n      = cpu_rdata;
        hit_n        = cpu_hit;
        mreq_valid_n = mem_req_valid;
        mreq_we_n    = mem_req_we;
        maddr_n      = mem_addr;
        mwdata_n     = mem_wdata;
        hit_cnt_n    = hit_count;
        miss_cnt_n   = miss_count;
        wr_en        = 1'b0;
        wr_dirty     = 1'b0;
        wr_data      = req_wdata;

        case (state)
            IDLE: begin
                if (cpu_req_valid && cpu_req_ready) begin
                    req_rwb_n   = cpu_rwb;
                    req_addr_n  = cpu_addr;
                    req_wdata_n = cpu_wdata;
                    ready_n     = 1'b0;
                    state_n     = COMPARE;
                end
            end
            COMPARE: begin
                if (lookup_hit_c) begin
                    resp_valid_n = 1'b1;
                    hit_n        = 1'b1;
                    ready_n      = 1'b1;
                    hit_cnt_n    = sat_inc(hit_count);
                    state_n      = IDLE;
                    if (req_rwb == RWB_READ) begin
                        rdata_n = line_data_c;
                    end else begin
                        rdata_n  = '0;
                        wr_en    = 1'b1;
                        wr_dirty = 1'b1;
                    end
                end else begin
                    miss_cnt_n   = sat_inc(miss_count);
                    mreq_valid_n = 1'b1;
                    if (line_valid_c && line_dirty_c) begin
                        mreq_we_n = 1'b1;
                        maddr_n   = {line_tag_c, idx};
                        mwdata_n  = line_data_c;
                        state_n   = WRITEBACK;
                    end else begin
                        mreq_we_n = 1'b0;
                        maddr_n   = req_addr;
                        mwdata_n  = '0;
                        state_n   = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                // Victim accepted: switch straight to the fill request, no idle gap.
                if (mem_done_c) begin
                    mreq_we_n = 1'b0;
                    maddr_n   = req_addr;
                    mwdata_n  = '0;
                    state_n   = ALLOCATE;
                end
            end
            ALLOCATE: begin
                if (mem_done_c) begin
                    wr_en        = 1'b1;
                    wr_dirty     = (req_rwb == RWB_WRITE);
                    wr_data      = (req_rwb == RWB_READ) ? mem_rdata : req_wdata;
                    mreq_valid_n = 1'b0;
                    mreq_we_n    = 1'b0;
                    resp_valid_n = 1'b1;
                    hit_n        = 1'b0;
                    rdata_n      = (req_rwb == RWB_READ) ? mem_rdata : '0;
                    ready_n      = 1'b1;
                    state_n      = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/param_wb_cache.md
Name: param_wb_cache

Overview:
- Parametrised direct-mapped, write-back, write-allocate cache controller between the processor and the RAM.
- Generalises the existing one-word-per-line cache in address width, data width and line count.
- Adds: valid/ready handshake on the processor side, request/ack handshake on the memory side (any memory latency), dirty-line write-back, and saturating hit/miss counters.

Parameters:
- ADDR_W, 6, processor/memory address width.
- DATA_W, 8, data word width; one word per line.
- INDEX_W, 3, index bits; LINES = 2**INDEX_W; TAG_W = ADDR_W-INDEX_W (INDEX_W < ADDR_W).
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req_valid  in  1  processor request present.
- cpu_req_ready  out  1  controller can accept a request (high only in IDLE).
- cpu_rwb  in  1  1=read, 0=write.
- cpu_addr  in  ADDR_W  request address; index=addr[INDEX_W-1:0], tag=upper bits.
- cpu_wdata  in  DATA_W  write data.
- cpu_resp_valid  out  1  one-cycle response pulse.
- cpu_rdata  out  DATA_W  read data; 0 for writes.
- cpu_hit  out  1  request was a hit; held until the next response.
- mem_req_valid  out  1  memory request, held until acked.
- mem_req_we  out  1  1=write-back, 0=line fill.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  write-back data.
- mem_ack  in  1  memory accepted write / returns read data this cycle.
- mem_rdata  in  DATA_W  fill data, valid with mem_ack.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Reset (async, reset=0):
  - all valid and dirty bits are cleared; state goes to IDLE.
  - all outputs are 0 except cpu_req_ready, which is 1.
  - the data/tag arrays are not reset.
- FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE. All outputs are registered.
- IDLE:
  - cpu_req_ready=1.
  - On cpu_req_valid&cpu_req_ready, latch rwb/addr/wdata, then go to COMPARE.
- COMPARE (1 cycle): hit = valid[idx] & (tag[idx]==req_tag).
  - Hit read: rdata = data[idx].
  - Hit write: data[idx] = wdata, dirty[idx] = 1.
  - On a hit, register cpu_resp_valid=1 and cpu_hit=1, increment hit_count, return to IDLE.
  - Hit latency: the response is seen 2 cycles after the accept edge, and cpu_req_ready is high in the same cycle as the response.
- Miss:
  - increment miss_count.
  - if valid[idx] & dirty[idx], go to WRITEBACK; otherwise go to ALLOCATE.
- WRITEBACK:
  - mem_req_valid=1, we=1, addr={tag[idx],idx}, wdata=data[idx].
  - On mem_ack, go to ALLOCATE.
- ALLOCATE:
  - mem_req_valid=1, we=0, addr=req_addr.
  - On mem_ack: data[idx] = (write ? wdata : mem_rdata), tag=req_tag, valid=1, dirty=write.
  - Register the response (cpu_hit=0; rdata = mem_rdata for reads, 0 for writes), then go to IDLE.
- Memory handshake:
  - mem_ack is sampled only while mem_req_valid=1.
  - An ack in the first request cycle is legal.
  - mem_req_valid drops in the cycle after the ack; between WRITEBACK and ALLOCATE it re-asserts with the new fields (no idle gap required).
- Counters: increment once per request and stick at 2**CNT_W-1; cleared only by reset.
- Reset mid-operation: any pending request is dropped, mem_req_valid goes to 0 asynchronously, and dirty data is lost (documented, not an error).
- cpu_req_valid while not ready is ignored, with no side effect.

Decomposition:
- Package cache_pkg:
  - state enum (IDLE, COMPARE, WRITEBACK, ALLOCATE).
  - RWB_READ/RWB_WRITE constants.
  - localparam helper for TAG_W.
- Sub-module cache_line_array:
  - LINES x {valid, dirty, tag, data} storage.
  - valid/dirty async-cleared.
  - one read port (combinational on index) and one write port.

Test Plan (defaults; memory model acks after 3 cycles unless stated):
- Cold read miss: reset, read 0x05; memory holds 0xA5 -> single mem read at 0x05 (we=0), no write-back, resp rdata=0xA5, hit=0, miss_count=1.
- Read hit: read 0x05 again -> no mem_req_valid, resp 2 cycles after accept, rdata=0xA5, hit=1, hit_count=1.
- Dirty eviction: write 0x3C to 0x05 (hit), then read 0x0D (same index, tag 1) -> mem write addr 0x05 data 0x3C, then mem read 0x0D, returns memory value, hit=0.
- Write-allocate on a clean line: write 0x77 to 0x12 (miss) -> one mem read 0x12, no mem write; then read 0x12 -> rdata=0x77, hit=1, no memory traffic.
- Zero-wait memory: mem_ack tied high, back-to-back reads 0x00..0x07 then 0x08 -> each miss takes exactly one mem cycle, no double requests, counters exact.
- Reset mid-write-back: drive reset=0 while in WRITEBACK -> mem_req_valid=0 the same cycle; after release, read 0x05 misses with no write-back.
- Counter saturation (CNT_W=2): 5 hits -> hit_count stays 3.
